// File: rtl/mvau_wmem_sched.sv
// mvau_wmem_sched: weight-memory read scheduler for one MVAU PE lane.
// Walks the ROM in NF-outer / SF-inner order and pairs each word with an activation slot.
module mvau_wmem_sched #(
    parameter int SF           = 4,
    parameter int NF           = 2,
    parameter int WMEM_DEPTH   = 8,
    parameter int WMEM_ADDR_BW = 3,
    parameter int SF_BW        = (SF > 1) ? $clog2(SF) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_v,
    output logic                    in_rdy,
    output logic                    act_wr_en,
    output logic [SF_BW-1:0]        act_addr,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    wdata_v,
    input  logic                    out_rdy,
    output logic                    act_live,
    output logic                    sf_last,
    output logic                    nf_last,
    output logic                    vec_last
);
    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [SF_BW-1:0] SF_MAX = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0] NF_MAX = NF_BW'(NF - 1);

    if (WMEM_DEPTH != SF * NF) begin : g_bad_depth
        $error("WMEM_DEPTH must equal SF*NF");
    end

    logic [SF_BW-1:0]        sf_c_q, sf_c_d, sf_q, sf_d;
    logic [NF_BW-1:0]        nf_c_q, nf_c_d, nf_q, nf_d;
    logic [WMEM_ADDR_BW-1:0] addr_c_q, addr_c_d, addr_q, addr_d;
    logic                    wdata_v_q, wdata_v_d;
    logic                    slot_free, issue, sf_wrap, nf_wrap;

    assign slot_free = !wdata_v_q || out_rdy;
    assign issue     = slot_free && (nf_c_q != '0 || in_v);
    assign sf_wrap   = sf_c_q == SF_MAX;
    assign nf_wrap   = nf_c_q == NF_MAX;

    // The ROM has no enable: during a stall it keeps re-reading the pending address.
    assign wmem_addr = issue ? addr_c_q : addr_q;
    assign in_rdy    = aresetn && slot_free && nf_c_q == '0;
    assign act_wr_en = in_v && in_rdy;
    assign act_addr  = sf_c_q;
    assign wdata_v   = wdata_v_q;
    assign act_live  = wdata_v_q && nf_q == '0;
    assign sf_last   = wdata_v_q && sf_q == SF_MAX;
    assign nf_last   = wdata_v_q && nf_q == NF_MAX;
    assign vec_last  = sf_last && nf_last;

    always_comb begin
        sf_c_d    = sf_c_q;
        nf_c_d    = nf_c_q;
        addr_c_d  = addr_c_q;
        addr_d    = addr_q;
        sf_d      = sf_q;
        nf_d      = nf_q;
        wdata_v_d = wdata_v_q;
        if (issue) begin
            addr_d    = addr_c_q;
            sf_d      = sf_c_q;
            nf_d      = nf_c_q;
            wdata_v_d = 1'b1;
            sf_c_d    = sf_wrap ? '0 : sf_c_q + 1'b1;
            nf_c_d    = sf_wrap ? (nf_wrap ? '0 : nf_c_q + 1'b1) : nf_c_q;
            addr_c_d  = (sf_wrap && nf_wrap) ? '0 : addr_c_q + 1'b1;
        end else if (out_rdy) begin
            wdata_v_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sf_c_q    <= '0;
            nf_c_q    <= '0;
            addr_c_q  <= '0;
            addr_q    <= '0;
            sf_q      <= '0;
            nf_q      <= '0;
            wdata_v_q <= 1'b0;
        end else begin
            sf_c_q    <= sf_c_d;
            nf_c_q    <= nf_c_d;
            addr_c_q  <= addr_c_d;
            addr_q    <= addr_d;
            sf_q      <= sf_d;
            nf_q      <= nf_d;
            wdata_v_q <= wdata_v_d;
        end
    end
endmodule

// File: tb/tb_mvau_wmem_sched.sv
// tb_mvau_wmem_sched: directed bench for the weight-memory scheduler (SF=4, NF=2).
// A model ROM returns 0xA0+address with one cycle of latency.
module tb_mvau_wmem_sched;
    logic       aclk = 1'b0, aresetn = 1'b1, in_v = 1'b0, out_rdy = 1'b1;
    logic       in_rdy, act_wr_en, wdata_v, act_live, sf_last, nf_last, vec_last;
    logic [1:0] act_addr;
    logic [2:0] wmem_addr;
    logic [7:0] rom_q;
    int         errs = 0, checks = 0, p = 0, exp_n = 0;

    mvau_wmem_sched #(.SF(4), .NF(2), .WMEM_DEPTH(8), .WMEM_ADDR_BW(3)) dut (
        .aclk(aclk), .aresetn(aresetn), .in_v(in_v), .in_rdy(in_rdy),
        .act_wr_en(act_wr_en), .act_addr(act_addr), .wmem_addr(wmem_addr),
        .wdata_v(wdata_v), .out_rdy(out_rdy), .act_live(act_live),
        .sf_last(sf_last), .nf_last(nf_last), .vec_last(vec_last)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) rom_q <= 8'hA0 + 8'(wmem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then drive inputs and settle before sampling.
    task automatic tick(input logic v, input logic r);
        @(posedge aclk);
        #1;
        in_v = v;
        out_rdy = r;
        #1;
    endtask

    initial begin
        in_v = 1'b1;
        #1 aresetn = 1'b0;
        #1;
        chk("rst_wdata_v", wdata_v, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_act_wr_en", act_wr_en, 0);
        chk("rst_wmem_addr", wmem_addr, 0);
        chk("rst_act_addr", act_addr, 0);
        chk("rst_flags", {act_live, sf_last, nf_last, vec_last}, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        #1;
        // Streaming: two full vectors and into the third, no bubbles.
        for (int k = 0; k < 22; k++) begin
            p = (k + 7) % 8;
            chk("s1_wmem_addr", wmem_addr, k % 8);
            chk("s1_in_rdy", in_rdy, (k % 8) < 4);
            chk("s1_act_wr_en", act_wr_en, (k % 8) < 4);
            chk("s1_act_addr", act_addr, k % 4);
            chk("s1_wdata_v", wdata_v, k > 0);
            if (k > 0) begin
                chk("s1_rom", rom_q, 8'hA0 + p);
                chk("s1_act_live", act_live, p < 4);
                chk("s1_sf_last", sf_last, (p % 4) == 3);
                chk("s1_nf_last", nf_last, p >= 4);
                chk("s1_vec_last", vec_last, p == 7);
            end
            tick(1, 1);
        end
        // Pending pair is word 5: stall for three cycles.
        out_rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("s2_wdata_v", wdata_v, 1);
            chk("s2_wmem_addr", wmem_addr, 5);
            chk("s2_rom", rom_q, 8'hA5);
            chk("s2_in_rdy", in_rdy, 0);
            chk("s2_nf_last", nf_last, 1);
            tick(1, i == 2);
        end
        chk("s2_resume_addr", wmem_addr, 6);
        chk("s2_resume_rom", rom_q, 8'hA5);
        tick(1, 1);
        chk("s2_adv_rom", rom_q, 8'hA6);
        chk("s2_adv_wmem_addr", wmem_addr, 7);
        // Asynchronous reset mid-vector, between edges.
        #1 aresetn = 1'b0;
        #1;
        chk("s5_wdata_v", wdata_v, 0);
        chk("s5_in_rdy", in_rdy, 0);
        chk("s5_act_wr_en", act_wr_en, 0);
        chk("s5_wmem_addr", wmem_addr, 0);
        chk("s5_nf_last", nf_last, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        #1;
        chk("s5_rel_in_rdy", in_rdy, 1);
        chk("s5_rel_wmem_addr", wmem_addr, 0);
        chk("s5_rel_wdata_v", wdata_v, 0);
        tick(1, 1);
        chk("s5_first_v", wdata_v, 1);
        chk("s5_first_live", act_live, 1);
        chk("s5_first_rom", rom_q, 8'hA0);
        chk("s3_c1_wmem_addr", wmem_addr, 1);
        chk("s3_c1_wr_en", act_wr_en, 1);
        // Input gap of two cycles after the second word.
        tick(0, 1);
        chk("s3_c2_wdata_v", wdata_v, 1);
        chk("s3_c2_rom", rom_q, 8'hA1);
        chk("s3_c2_wmem_addr", wmem_addr, 1);
        chk("s3_c2_wr_en", act_wr_en, 0);
        chk("s3_c2_in_rdy", in_rdy, 1);
        tick(0, 1);
        chk("s3_c3_wdata_v", wdata_v, 0);
        chk("s3_c3_wmem_addr", wmem_addr, 1);
        chk("s3_c3_wr_en", act_wr_en, 0);
        tick(1, 1);
        chk("s3_c4_wdata_v", wdata_v, 0);
        chk("s3_c4_wmem_addr", wmem_addr, 2);
        chk("s3_c4_wr_en", act_wr_en, 1);
        chk("s3_c4_act_addr", act_addr, 2);
        tick(1, 1);
        chk("s3_c5_wdata_v", wdata_v, 1);
        chk("s3_c5_rom", rom_q, 8'hA2);
        chk("s3_c5_live", act_live, 1);
        // Random backpressure: the consumed stream must continue 2,3,...,7,0,1,...
        exp_n = 2;
        for (int c = 0; c < 2000 && exp_n < 82; c++) begin
            out_rdy = 1'($urandom_range(0, 1));
            #1;
            if (wdata_v && out_rdy) begin
                chk("s6_rom", rom_q, 8'hA0 + (exp_n % 8));
                chk("s6_vec_last", vec_last, (exp_n % 8) == 7);
                exp_n++;
            end
            @(posedge aclk);
            #1;
        end
        chk("s6_consumed", exp_n, 82);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mvau_wmem_sched.md
# mvau_wmem_sched

Weight-memory read scheduler for one MVAU PE lane. It walks the weight memory in fold order: neuron fold NF is the outer loop, synapse fold SF is the inner loop. It pairs each weight word with an input-activation slot and streams weight-valid plus fold markers to the downstream MAC. The block sits between the input-activation stream, the activation reuse buffer, the single-cycle-latency weight ROM and the MAC/accumulator. It handles backpressure without an enable on the ROM.

## Interface
Parameters:
- SF, 4, synapse fold: weight words per output neuron group.
- NF, 2, neuron fold: neuron groups per input vector.
- WMEM_DEPTH, 8, weight memory depth; must equal SF*NF.
- WMEM_ADDR_BW, 3, weight address width; 2^WMEM_ADDR_BW >= WMEM_DEPTH.
- SF_BW, max(1,$clog2(SF)), activation buffer address width.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  reset, asynchronous and active-low.
- in_v  in  1  input activation word valid.
- in_rdy  out  1  input activation word accepted when in_v && in_rdy.
- act_wr_en  out  1  write the accepted input word to the reuse buffer.
- act_addr  out  SF_BW  reuse buffer address (write and read), equals sf_c.
- wmem_addr  out  WMEM_ADDR_BW  address into the weight ROM (1-cycle read latency).
- wdata_v  out  1  ROM output and reuse-buffer output currently hold a valid pair.
- out_rdy  in  1  downstream consumes the pair when wdata_v && out_rdy.
- act_live  out  1  pending pair belongs to NF=0: use the live input word, not the buffer.
- sf_last  out  1  pending pair is the last SF step (accumulator flush).
- nf_last  out  1  pending pair is in the last neuron fold.
- vec_last  out  1  sf_last && nf_last; the input vector is fully processed.

## Operation
State:
- Next-to-issue pointers sf_c, nf_c and running address addr_c.
- Pending-pair tags addr_q, sf_q, nf_q, plus wdata_v.

Issue control:
- slot_free = !wdata_v || out_rdy.
- issue = slot_free && (nf_c != 0 || in_v).
- in_rdy = aresetn && slot_free && nf_c == 0.
- act_wr_en = in_v && in_rdy.

On issue:
- addr_q <= addr_c, sf_q <= sf_c, nf_q <= nf_c, wdata_v <= 1.
- sf_c increments.
- At sf_c == SF-1: sf_c wraps to 0 and nf_c increments.
- At nf_c == NF-1 with sf_c == SF-1: both wrap to 0 and addr_c wraps to 0.
- Otherwise addr_c increments. No multiplier is used.

On consume without issue (out_rdy && wdata_v && !issue): wdata_v <= 0. addr_q is held.

Address and data alignment:
- wmem_addr = issue ? addr_c : addr_q (combinational).
- The ROM output therefore always equals weight_mem[addr_q] one cycle later.
- During a stall the ROM re-reads addr_q, so its output is stable.

Output decode:
- act_live = nf_q == 0; sf_last = sf_q == SF-1; nf_last = nf_q == NF-1; vec_last = sf_last && nf_last.
- All are qualified by wdata_v.
- NF == 1: every pass requires input; the buffer is written but never read back.
- SF == 1: sf_last is constant 1 whenever wdata_v is high.

## Timing
Reset (asynchronous assert):
- wdata_v=0, in_rdy=0, act_wr_en=0, wmem_addr=0, act_addr=0.
- Counters and tags are 0; flags are 0.

Release: synchronous at the next edge; in_rdy=1 in the first cycle after release.

Latency: issue at edge t gives wdata_v=1 and valid ROM/buffer data after edge t.

Throughput:
- With out_rdy=1 and a continuous in_v, one pair per cycle with no bubbles.
- This includes the NF=0 to NF>0 transitions and the vector wrap.

Stalls:
- out_rdy=0 with wdata_v=1: all state and outputs are held.
- in_rdy=0 while a pair is pending.

Input gaps: in_v=0 while nf_c==0 gives no issue. wdata_v falls after the pending pair is consumed.

Reset mid-vector: the pending pair is discarded and the pointers restart at (0,0). No partial-vector resume.

## Test plan
All scenarios use SF=4, NF=2, WMEM_DEPTH=8.
1. Reset, then in_v held 1 and out_rdy=1:
   - wmem_addr sequence 0..7 then 0 with no gaps.
   - in_rdy high for 4 cycles, then low for 4.
   - act_live high for pairs 0-3; sf_last at addr_q 3 and 7; vec_last at addr_q 7.
2. out_rdy=0 for 3 cycles while addr_q=5:
   - wdata_v stays 1; wmem_addr and ROM output stay at word 5.
   - addr_q advances to 6 on the first cycle out_rdy returns to 1.
3. in_v=0 for 2 cycles after the second input word, out_rdy=1:
   - wdata_v drops for 2 cycles and addr_q holds at 1.
   - Issue resumes at addr 2; act_wr_en is asserted only on accepted words.
4. Two back-to-back vectors:
   - act_addr write sequence 0,1,2,3, then read 0,1,2,3.
   - The second vector's in_rdy rises in the cycle after vec_last is issued.
5. Assert aresetn=0 asynchronously at addr_q=6:
   - wdata_v and in_rdy drop immediately, without waiting for an edge.
   - After release, wmem_addr restarts at 0 and act_live=1 on the first pair.
6. Random out_rdy (50%) with continuous in_v over 10 vectors:
   - Consumed address stream is exactly 0..7 repeated.
   - No pair is lost or duplicated.
